// File: rtl/code_entry_lock.sv
// Keypad code-entry lock: collects up to four BCD digits, checks them against CODE,
// and sequences OPEN / FAIL / LOCKOUT using ticks edge-detected from divided_clk.
module code_entry_lock #(
    parameter logic [15:0] CODE          = 16'h1234,
    parameter int unsigned MAX_ATTEMPTS  = 3,
    parameter int unsigned TIMEOUT_TICKS = 100,
    parameter int unsigned OPEN_TICKS    = 100,
    parameter int unsigned FAIL_TICKS    = 20,
    parameter int unsigned LOCKOUT_TICKS = 600
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       divided_clk,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       enter,
    output logic       unlocked,
    output logic       lockout,
    output logic       blink,
    output logic [2:0] digit_count,
    output logic [1:0] attempts,
    output logic [2:0] state
);

    localparam int unsigned MAX_A = (TIMEOUT_TICKS > OPEN_TICKS) ? TIMEOUT_TICKS : OPEN_TICKS;
    localparam int unsigned MAX_B = (FAIL_TICKS > LOCKOUT_TICKS) ? FAIL_TICKS : LOCKOUT_TICKS;
    localparam int unsigned MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TW    = $clog2(MAX_T + 1);

    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);
    localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_TICKS - 1);
    localparam logic [TW-1:0] FAIL_LAST = TW'(FAIL_TICKS - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_FAIL    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   buf_q, buf_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [1:0]    att_q, att_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          blink_q, blink_d;
    logic          unlocked_q, lockout_q;
    logic          dc_q;
    logic          tick;
    logic          key_ok;
    logic          key_acc;
    logic          hold_blink;

    assign tick = divided_clk & ~dc_q;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        att_d   = att_q;
        key_acc = 1'b0;
        // enter outranks a simultaneous digit in every state
        key_ok  = key_valid && (key_digit <= 4'd9) && !enter;

        case (state_q)
            S_IDLE: begin
                if (key_ok) begin
                    key_acc = 1'b1;
                    state_d = S_ENTRY;
                    buf_d   = {buf_q[11:0], key_digit};
                    cnt_d   = 3'd1;
                end
            end
            S_ENTRY: begin
                if (enter) begin
                    state_d = S_CHECK;
                end else if (key_ok) begin
                    key_acc = 1'b1;
                    if (cnt_q < 3'd4) begin
                        buf_d = {buf_q[11:0], key_digit};
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (tick && (tick_cnt_q == TO_LAST)) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_CHECK: begin
                buf_d = '0;
                cnt_d = '0;
                if ((cnt_q == 3'd4) && (buf_q == CODE)) begin
                    state_d = S_OPEN;
                    att_d   = '0;
                end else if ((32'(att_q) + 32'd1) == MAX_ATTEMPTS) begin
                    state_d = S_LOCKOUT;
                    att_d   = '0;
                end else begin
                    state_d = S_FAIL;
                    att_d   = att_q + 2'd1;
                end
            end
            S_OPEN: begin
                if (enter || (tick && (tick_cnt_q == OPEN_LAST))) begin
                    state_d = S_IDLE;
                end
            end
            S_FAIL: begin
                if (tick && (tick_cnt_q == FAIL_LAST)) begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (tick && (tick_cnt_q == LOCK_LAST)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                buf_d   = '0;
                cnt_d   = '0;
            end
        endcase

        if ((state_d != state_q) || key_acc) begin
            tick_cnt_d = '0;
        end else if (tick) begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end else begin
            tick_cnt_d = tick_cnt_q;
        end

        // blink only runs while staying in FAIL/LOCKOUT; entry and exit force it low
        hold_blink = (state_d == state_q) && ((state_q == S_FAIL) || (state_q == S_LOCKOUT));
        blink_d    = hold_blink ? (blink_q ^ tick) : 1'b0;
    end

    always_ff @(posedge clk_in) begin
        dc_q <= divided_clk;
        if (!rst) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            cnt_q      <= '0;
            att_q      <= '0;
            tick_cnt_q <= '0;
            blink_q    <= 1'b0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            att_q      <= att_d;
            tick_cnt_q <= tick_cnt_d;
            blink_q    <= blink_d;
            unlocked_q <= (state_d == S_OPEN);
            lockout_q  <= (state_d == S_LOCKOUT);
        end
    end

    assign unlocked    = unlocked_q;
    assign lockout     = lockout_q;
    assign blink       = blink_q;
    assign digit_count = cnt_q;
    assign attempts    = att_q;
    assign state       = state_q;

endmodule
